atomic_sequencer: RTL

Sequences RV32 A-extension atomics (LR.W, SC.W, AMO*.W) onto the single data-memory port of the RS5 core. It sits beside the load/store path in execute, stalls the pipeline while a read-modify-write is in flight, and owns the single LR/SC reservation. Used when the core is built with AMO_ZALRSC, AMO_ZAAMO or AMO_A.

---
 rtl/atomic_sequencer_pkg.sv | 31 +++
 rtl/atomic_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/atomic_sequencer_pkg.sv
// atomic_sequencer_pkg
// Purpose: instruction-class and AMO-operation encodings shared by the
//          atomic sequencer and anything that drives it.
//   iType_e       : instruction class; only LR_W, SC_W and AMO_W are atomics.
//   iTypeAtomic_e : one-hot AMO operation. AMONOP (all zeros) and any
//                   non-one-hot value make the AMO rewrite the old word.
package atomic_sequencer_pkg;

    typedef enum logic [2:0] {
        IT_ALU   = 3'd0,
        IT_LOAD  = 3'd1,
        IT_STORE = 3'd2,
        LR_W     = 3'd3,
        SC_W     = 3'd4,
        AMO_W    = 3'd5
    } iType_e;

    typedef enum logic [8:0] {
        AMONOP  = 9'h000,
        AMOSWAP = 9'h001,
        AMOADD  = 9'h002,
        AMOXOR  = 9'h004,
        AMOAND  = 9'h008,
        AMOOR   = 9'h010,
        AMOMIN  = 9'h020,
        AMOMAX  = 9'h040,
        AMOMINU = 9'h080,
        AMOMAXU = 9'h100
    } iTypeAtomic_e;

endpackage

// File: rtl/atomic_sequencer.sv
// atomic_sequencer
// Purpose: runs RV32 LR.W / SC.W / AMO*.W over the single data-memory port,
//          stalling the pipeline while a sequence is in flight, and owns the
//          single LR/SC reservation.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   req_i, instr_i, amo_op_i  : atomic request, class and AMO operation
//   addr_i, rs2_i             : effective address and operand
//   clear_reservation_i       : trap/interrupt, drops the reservation
//   ext_store_i/_addr_i       : store by another agent, drops a matching reservation
//   mem_*                     : data-memory read strobe, byte enables, address, data
//   hold_o                    : pipeline stall
//   done_o, result_o, misaligned_o : completion pulse with rd value / alignment fault
// Handshake: a request is accepted in IDLE when req_i is high with an atomic
// instr_i; the requester keeps req_i and operands stable until the one-cycle
// done_o pulse, which arrives in the DONE state. Operands are latched on
// acceptance so the sequence finishes even if req_i drops early.
module atomic_sequencer
    import atomic_sequencer_pkg::*;
#(
    parameter int unsigned LRSC_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_i,
    input  iType_e       instr_i,
    input  iTypeAtomic_e amo_op_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  rs2_i,
    input  logic         clear_reservation_i,
    input  logic         ext_store_i,
    input  logic [31:0]  ext_store_addr_i,
    output logic         mem_read_enable_o,
    output logic [3:0]   mem_write_enable_o,
    output logic [31:0]  mem_address_o,
    output logic [31:0]  mem_data_o,
    input  logic [31:0]  mem_data_i,
    output logic         hold_o,
    output logic         done_o,
    output logic [31:0]  result_o,
    output logic         misaligned_o
);

    localparam logic [7:0] TIMEOUT = 8'(LRSC_TIMEOUT);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_e;

    state_e       state, state_n;
    iType_e       kind_q;
    iTypeAtomic_e op_q;
    logic [29:0]  addr_q;
    logic [31:0]  rs2_q;
    logic [31:0]  data_q;
    logic         sc_fail_q;
    logic         mis_q;
    logic         res_valid_q, res_valid_n;
    logic [29:0]  res_addr_q, res_addr_n;
    logic [7:0]   res_cnt_q, res_cnt_n;

    logic         accept;
    logic         misaligned_in;
    logic         ext_hit_now;
    logic         sc_ok;
    logic         sc_clear;
    logic [31:0]  amo_value;
    logic [1:0]   ext_addr_unused;

    assign ext_addr_unused = ext_store_addr_i[1:0];

    assign accept        = (state == IDLE) && req_i &&
                           (instr_i == LR_W || instr_i == SC_W || instr_i == AMO_W);
    assign misaligned_in = (addr_i[1:0] != 2'b00);
    // A same-cycle invalidation beats the SC: the reservation must survive this
    // cycle's clear and snoop for the store-conditional to succeed.
    assign ext_hit_now   = ext_store_i && (ext_store_addr_i[31:2] == res_addr_q);
    assign sc_ok         = res_valid_q && (res_addr_q == addr_i[31:2]) &&
                           !clear_reservation_i && !ext_hit_now;
    assign sc_clear      = accept && (instr_i == SC_W) && !misaligned_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            kind_q      <= IT_ALU;
            op_q        <= AMONOP;
            addr_q      <= '0;
            rs2_q       <= '0;
            data_q      <= '0;
            sc_fail_q   <= 1'b0;
            mis_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_cnt_q   <= '0;
        end else begin
            state       <= state_n;
            res_valid_q <= res_valid_n;
            res_addr_q  <= res_addr_n;
            res_cnt_q   <= res_cnt_n;
            if (accept) begin
                kind_q    <= instr_i;
                op_q      <= amo_op_i;
                addr_q    <= addr_i[31:2];
                rs2_q     <= rs2_i;
                mis_q     <= misaligned_in;
                sc_fail_q <= !sc_ok;
            end
            if (state == CAP) begin
                data_q <= mem_data_i;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned_in)          state_n = DONE;
                    else if (instr_i == SC_W)   state_n = sc_ok ? WR : DONE;
                    else                        state_n = RD;
                end
            end
            RD:      state_n = CAP;
            CAP:     state_n = (kind_q == LR_W) ? DONE : WR;
            WR:      state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Reservation: ageing first, then a fresh LR capture, then every
    // invalidation source, so invalidation always has the last word.
    always_comb begin
        res_valid_n = res_valid_q;
        res_addr_n  = res_addr_q;
        res_cnt_n   = res_cnt_q;
        if (res_valid_q) begin
            res_cnt_n = res_cnt_q - 8'd1;
            if (res_cnt_q == 8'd1) res_valid_n = 1'b0;
        end
        if (state == CAP && kind_q == LR_W) begin
            res_valid_n = 1'b1;
            res_addr_n  = addr_q;
            res_cnt_n   = TIMEOUT;
        end
        if (clear_reservation_i || sc_clear ||
            (ext_store_i && ext_store_addr_i[31:2] == res_addr_n)) begin
            res_valid_n = 1'b0;
            res_cnt_n   = '0;
        end
    end

    always_comb begin
        amo_value = data_q;
        case (op_q)
            AMOSWAP: amo_value = rs2_q;
            AMOADD:  amo_value = data_q + rs2_q;
            AMOXOR:  amo_value = data_q ^ rs2_q;
            AMOAND:  amo_value = data_q & rs2_q;
            AMOOR:   amo_value = data_q | rs2_q;
            AMOMIN:  amo_value = ($signed(data_q) < $signed(rs2_q)) ? data_q : rs2_q;
            AMOMAX:  amo_value = ($signed(data_q) > $signed(rs2_q)) ? data_q : rs2_q;
            AMOMINU: amo_value = (data_q < rs2_q) ? data_q : rs2_q;
            AMOMAXU: amo_value = (data_q > rs2_q) ? data_q : rs2_q;
            default: amo_value = data_q;
        endcase
    end

    always_comb begin
        mem_read_enable_o  = (state == RD);
        mem_write_enable_o = (state == WR) ? 4'b1111 : 4'b0000;
        mem_address_o      = (state == RD || state == WR) ? {addr_q, 2'b00} : 32'h0;
        mem_data_o         = 32'h0;
        if (state == WR) mem_data_o = (kind_q == SC_W) ? rs2_q : amo_value;
        hold_o             = accept || state == RD || state == CAP || state == WR;
        done_o             = (state == DONE);
        misaligned_o       = (state == DONE) && mis_q;
        result_o           = 32'h0;
        if (state == DONE && !mis_q) result_o = (kind_q == SC_W) ? {31'h0, sc_fail_q} : data_q;
    end

endmodule
